// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// data access (D, loads/stores). One requester is granted at a time and the
// memory request is held until the memory acknowledges it. Data wins the
// arbitration, but only MAX_DSTREAK times in a row while a fetch is waiting.
// A watchdog aborts any access that sees no ack for TIMEOUT busy cycles.
//
// Ports
//   clka, rst                 clock (rising edge), synchronous active-high reset
//   if_req/if_addr            fetch request (level) and address
//   if_rdata/if_ready         fetch data and 1-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request (level), store flag, address, data
//   d_rdata/d_ready           load data and 1-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory request
//   mem_rdata/mem_ack         memory read data and completion
//   stall_if/stall_mem        per-stage stall requests to the pipeline
//   bus_err                   sticky watchdog-timeout flag (cleared only by rst)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  localparam int SC_W = $clog2(MAX_DSTREAK + 1);
  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [SC_W-1:0] STREAK_MAX = SC_W'(MAX_DSTREAK);
  localparam logic [SC_W-1:0] STREAK_ONE = SC_W'(1);
  localparam logic [WD_W-1:0] WDOG_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WDOG_ONE   = WD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;

  state_t            state_r;
  logic [SC_W-1:0]   streak_cnt_r;
  logic [WD_W-1:0]   wdog_cnt_r;

  logic grant_d_s;
  logic grant_i_s;
  logic timeout_s;

  // Arbitration in IDLE and watchdog expiry in BUSY; an ack in the expiry
  // cycle takes precedence so a late but valid response is never discarded.
  always_comb begin
    grant_d_s = 1'b0;
    grant_i_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (d_req && (!if_req || (streak_cnt_r < STREAK_MAX))) begin
          grant_d_s = 1'b1;
        end else if (if_req) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b0;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (!mem_ack && (wdog_cnt_r == WDOG_LAST)) begin
          timeout_s = 1'b1;
        end else begin
          timeout_s = 1'b0;
        end
      end
      default: begin
        timeout_s = 1'b0;
      end
    endcase
  end

  // Completion pulses and read-data gating; an aborted access completes with
  // zero data so the requester never consumes whatever is on mem_rdata.
  always_comb begin
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if_rdata = {DATA_W{1'b0}};
    d_rdata  = {DATA_W{1'b0}};
    case (state_r)
      ST_IBUSY: begin
        if_ready = mem_ack | timeout_s;
        if (mem_ack) begin
          if_rdata = mem_rdata;
        end else begin
          if_rdata = {DATA_W{1'b0}};
        end
      end
      ST_DBUSY: begin
        d_ready = mem_ack | timeout_s;
        if (mem_ack) begin
          d_rdata = mem_rdata;
        end else begin
          d_rdata = {DATA_W{1'b0}};
        end
      end
      default: begin
        if_ready = 1'b0;
        d_ready  = 1'b0;
      end
    endcase
  end

  // Stall requests toward the pipeline hazard logic.
  always_comb begin
    stall_if  = if_req & ~if_ready;
    stall_mem = d_req & ~d_ready;
  end

  // Main FSM: grants, registered memory request, streak and watchdog counters.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      bus_err      <= 1'b0;
      streak_cnt_r <= {SC_W{1'b0}};
      wdog_cnt_r   <= {WD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_d_s) begin
            state_r    <= ST_DBUSY;
            mem_en     <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            wdog_cnt_r <= {WD_W{1'b0}};
            // Only data grants that overtake a waiting fetch extend the streak.
            if (if_req) begin
              if (streak_cnt_r < STREAK_MAX) begin
                streak_cnt_r <= streak_cnt_r + STREAK_ONE;
              end else begin
                streak_cnt_r <= streak_cnt_r;
              end
            end else begin
              streak_cnt_r <= {SC_W{1'b0}};
            end
          end else if (grant_i_s) begin
            state_r      <= ST_IBUSY;
            mem_en       <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            wdog_cnt_r   <= {WD_W{1'b0}};
            streak_cnt_r <= {SC_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        ST_IBUSY, ST_DBUSY: begin
          if (mem_ack || timeout_s) begin
            state_r <= ST_IDLE;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            if (timeout_s) begin
              bus_err <= 1'b1;
            end else begin
              bus_err <= bus_err;
            end
          end else begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule
